// File: rtl/msrv_pc_gen_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | msrv_pc_gen_unit: next-PC mux, PC register, boot hold and fetch handshake |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module msrv_pc_gen_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter bit              C_EXT       = 1'b0,
  parameter int              BOOT_CYCLES = 2,
  parameter int              CNT_W       = 8
) (
  input  logic             ms_risc32_mp_clk_in,
  input  logic             ms_risc32_mp_rst_in,
  input  logic [1:0]       pc_src_in,
  input  logic [XLEN-1:0]  epc_in,
  input  logic [XLEN-1:0]  trap_address_in,
  input  logic             branch_taken_in,
  input  logic [XLEN-1:0]  iaddr_in,
  input  logic             ahb_ready_in,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pc_plus_4_out,
  output logic [XLEN-1:0]  pc_mux_out,
  output logic [XLEN-1:0]  iaddr_out,
  output logic             fetch_valid_out,
  output logic             misaligned_instr_out,
  output logic [CNT_W-1:0] redirect_count_out
);

  localparam int              c_BW      = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);
  localparam logic [XLEN-1:0] c_FOUR    = XLEN'(4);
  localparam logic [XLEN-1:0] c_HW_MASK = ~XLEN'(1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_BW-1:0]  r_boot_cnt;
  logic [XLEN-1:0]  r_pc;
  logic             r_misaligned;
  logic [CNT_W-1:0] r_redirect_cnt;

  logic [XLEN-1:0]  w_pc_plus_4;
  logic [XLEN-1:0]  w_pc_mux;
  logic             w_misaligned;
  logic             w_active;
  logic             w_update;
  logic             w_redirect;
  logic             w_fetch_valid;

  always_comb begin
    w_pc_plus_4 = r_pc + c_FOUR;
    w_pc_mux    = w_pc_plus_4;
    case (pc_src_in)
      2'b00:   w_pc_mux = RESET_VEC;
      2'b01:   w_pc_mux = epc_in;
      2'b10:   w_pc_mux = trap_address_in;
      default: w_pc_mux = branch_taken_in ? (iaddr_in & c_HW_MASK) : w_pc_plus_4;
    endcase
  end

  always_comb begin
    w_misaligned = (pc_src_in == 2'b11) && branch_taken_in && (C_EXT == 1'b0) && iaddr_in[1];
    // The releasing cycle of a stall updates the PC directly, hence STALL counts as active.
    w_active     = ((r_state == ST_RUN) || (r_state == ST_STALL)) && ahb_ready_in;
    w_update     = w_active && !w_misaligned;
    w_redirect   = (pc_src_in != 2'b11) || branch_taken_in;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_valid = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt <= c_BW'(1)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_fetch_valid = 1'b1;
        if (!ahb_ready_in) w_state_nxt = ST_STALL;
      end
      ST_STALL: begin
        w_fetch_valid = 1'b1;
        if (ahb_ready_in) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge ms_risc32_mp_clk_in) begin
    if (ms_risc32_mp_rst_in) begin
      r_state        <= (BOOT_CYCLES > 0) ? ST_BOOT : ST_RUN;
      r_boot_cnt     <= c_BW'(BOOT_CYCLES);
      r_pc           <= RESET_VEC;
      r_misaligned   <= 1'b0;
      r_redirect_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_misaligned <= w_active && w_misaligned;
      if (r_state == ST_BOOT) r_boot_cnt <= r_boot_cnt - c_BW'(1);
      // Instructions are at least halfword aligned, so bit 0 never reaches the PC.
      if (w_update) r_pc <= w_pc_mux & c_HW_MASK;
      if (w_update && w_redirect && (r_redirect_cnt != {CNT_W{1'b1}}))
        r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
    end
  end

  assign pc_out               = r_pc;
  assign pc_plus_4_out        = w_pc_plus_4;
  assign pc_mux_out           = w_pc_mux;
  assign iaddr_out            = (r_state == ST_BOOT) ? RESET_VEC : r_pc;
  assign fetch_valid_out      = w_fetch_valid;
  assign misaligned_instr_out = r_misaligned;
  assign redirect_count_out   = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_msrv_pc_gen_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_msrv_pc_gen_unit: directed self-checking bench for msrv_pc_gen_unit    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_msrv_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic [31:0] epc, trap, iaddr;
  logic        br, ready;

  logic [31:0] pc0, pc4_0, mux0, ia0, pc1, pc4_1, mux1, ia1;
  logic        fv0, mis0, fv1, mis1;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv_pc_gen_unit dut0 (
    .ms_risc32_mp_clk_in (clk),   .ms_risc32_mp_rst_in (rst),
    .pc_src_in           (pc_src), .epc_in             (epc),
    .trap_address_in     (trap),  .branch_taken_in     (br),
    .iaddr_in            (iaddr), .ahb_ready_in        (ready),
    .pc_out              (pc0),   .pc_plus_4_out       (pc4_0),
    .pc_mux_out          (mux0),  .iaddr_out           (ia0),
    .fetch_valid_out     (fv0),   .misaligned_instr_out(mis0),
    .redirect_count_out  (cnt0)
  );

  msrv_pc_gen_unit #(.C_EXT(1'b1), .CNT_W(2)) dut1 (
    .ms_risc32_mp_clk_in (clk),   .ms_risc32_mp_rst_in (rst),
    .pc_src_in           (pc_src), .epc_in             (epc),
    .trap_address_in     (trap),  .branch_taken_in     (br),
    .iaddr_in            (iaddr), .ahb_ready_in        (ready),
    .pc_out              (pc1),   .pc_plus_4_out       (pc4_1),
    .pc_mux_out          (mux1),  .iaddr_out           (ia1),
    .fetch_valid_out     (fv1),   .misaligned_instr_out(mis1),
    .redirect_count_out  (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_src = 2'b11; br = 1'b0; ready = 1'b1;
    epc = '0; trap = '0; iaddr = '0;
    step(); step();
    check("rst_pc",   pc0, 32'h0);
    check("rst_fv",   32'(fv0), 32'h0);
    check("rst_cnt",  32'(cnt0), 32'h0);
    check("rst_mis",  32'(mis0), 32'h0);

    // Boot: two cycles of fetch_valid low after release
    rst = 1'b0; #1;
    check("boot1_fv", 32'(fv0), 32'h0);
    step();
    check("boot2_fv", 32'(fv0), 32'h0);
    check("boot2_pc", pc0, 32'h0);
    step();
    check("run_fv",   32'(fv0), 32'h1);
    check("run_pc0",  pc0, 32'h0);
    check("run_ia0",  ia0, 32'h0);
    check("run_p4",   pc4_0, 32'h4);
    step(); check("seq_pc4", pc0, 32'h4);
    step(); check("seq_pc8", pc0, 32'h8);
    step(); check("seq_pcC", pc0, 32'hC);
    check("seq_cnt",  32'(cnt0), 32'h0);

    // Taken branch, then exception return with odd epc
    br = 1'b1; iaddr = 32'h1122_3344; #1;
    check("br_mux",   mux0, 32'h1122_3344);
    step();
    check("br_pc",    pc0, 32'h1122_3344);
    check("br_cnt",   32'(cnt0), 32'h1);
    pc_src = 2'b01; epc = 32'hAABB_CCDD; #1;
    check("epc_mux",  mux0, 32'hAABB_CCDD);
    step();
    check("epc_pc",   pc0, 32'hAABB_CCDC);
    check("epc_cnt",  32'(cnt0), 32'h2);

    // Stall for three cycles with a pending trap redirect
    pc_src = 2'b10; trap = 32'h1122_3340; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc0, 32'hAABB_CCDC);
      check("stall_fv", 32'(fv0), 32'h1);
    end
    ready = 1'b1;
    step();
    check("rel_pc",   pc0, 32'h1122_3340);
    check("rel_cnt",  32'(cnt0), 32'h3);
    check("rel_cnt1", 32'(cnt1), 32'h3);

    // Misaligned target: held on C_EXT=0, taken on C_EXT=1 (counter saturated)
    pc_src = 2'b11; br = 1'b1; iaddr = 32'h0000_1006;
    step();
    check("mis_pc",   pc0, 32'h1122_3340);
    check("mis_flag", 32'(mis0), 32'h1);
    check("mis_cnt",  32'(cnt0), 32'h3);
    check("c_pc",     pc1, 32'h0000_1006);
    check("c_flag",   32'(mis1), 32'h0);
    check("c_cnt",    32'(cnt1), 32'h3);
    br = 1'b0;
    step();
    check("mis_clr",  32'(mis0), 32'h0);
    check("mis_seq",  pc0, 32'h1122_3344);
    check("c_seq",    pc1, 32'h0000_100A);

    // Wrap of pc+4 and fifth redirect on the 2-bit counter
    pc_src = 2'b10; trap = 32'hFFFF_FFFC;
    step();
    check("wrap_pc",  pc0, 32'hFFFF_FFFC);
    check("wrap_p4",  pc4_0, 32'h0);
    check("wrap_cnt", 32'(cnt0), 32'h4);
    check("sat_cnt",  32'(cnt1), 32'h3);
    pc_src = 2'b11;
    step();
    check("wrap_pc0", pc0, 32'h0);
    check("wrap_cnt2", 32'(cnt0), 32'h4);
    pc_src = 2'b00; #1;
    check("rv_mux",   mux0, 32'h0);
    pc_src = 2'b11;
    step();
    check("pre_pc",   pc0, 32'h4);

    // Reset during a stall with a pending trap redirect
    pc_src = 2'b10; trap = 32'h1234_5678; ready = 1'b0;
    step();
    check("stl2_pc",  pc0, 32'h4);
    rst = 1'b1;
    step();
    check("mrst_pc",  pc0, 32'h0);
    check("mrst_cnt", 32'(cnt0), 32'h0);
    check("mrst_fv",  32'(fv0), 32'h0);
    rst = 1'b0; ready = 1'b1;
    step();
    check("mboot_fv", 32'(fv0), 32'h0);
    check("mboot_pc", pc0, 32'h0);
    check("mboot_ia", ia0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
